// File: rtl/operand_fetch_pkg.sv
// Shared addressing-mode definitions for the operand fetch unit.
// Holds the MODE_* encoding seen on the decode interface, the fetch FSM
// state encoding, default widths and small decode helpers.
package operand_fetch_pkg;

  localparam int OF_ADDR_WIDTH = 24;
  localparam int OF_REG_WIDTH  = 32;

  // Largest operand byte count; larger requests are clipped to this.
  localparam logic [1:0] MAX_OPERAND_BYTES = 2'd3;

  typedef enum logic [3:0] {
    MODE_NONE           = 4'd0,
    MODE_A              = 4'd1,
    MODE_IMMEDIATE      = 4'd2,
    MODE_ZP             = 4'd3,
    MODE_INDEXED_X      = 4'd4,
    MODE_ABSOLUTE       = 4'd5,
    MODE_ABSOLUTE_X     = 4'd6,
    MODE_ABSOLUTE_Y     = 4'd7,
    MODE_INDIRECT_X     = 4'd8,
    MODE_INDIRECT_Y     = 4'd9,
    MODE_STACK_RELATIVE = 4'd10
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH_OP  = 3'd1,
    ST_FETCH_PTR = 3'd2,
    ST_CALC      = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // Operand byte count 0..7 mapped onto 0..3.
  function automatic logic [1:0] clip_bytes(input logic [2:0] n);
    return (n > 3'd3) ? MAX_OPERAND_BYTES : n[1:0];
  endfunction

  // Modes that follow a zero-page pointer after the operand bytes.
  function automatic logic is_indirect(input mode_e m);
    return (m == MODE_INDIRECT_X) || (m == MODE_INDIRECT_Y);
  endfunction

endpackage

// File: rtl/operand_fetch_ea_calc.sv
// Effective-address adder/mux used in the CALC state.
// Ports:
//   mode_i   latched addressing mode
//   op_i     assembled little-endian operand
//   pc_i     address of the first operand byte
//   x_i/y_i  index registers, already truncated to address width
//   ptr_i    16-bit pointer read from zero page (indirect modes)
//   ea_o     resolved effective address, modulo 2^ADDR_WIDTH
module operand_fetch_ea_calc
  import operand_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = OF_ADDR_WIDTH
) (
  input  mode_e                 mode_i,
  input  logic [ADDR_WIDTH-1:0] op_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [ADDR_WIDTH-1:0] x_i,
  input  logic [ADDR_WIDTH-1:0] y_i,
  input  logic [15:0]           ptr_i,
  output logic [ADDR_WIDTH-1:0] ea_o
);

  logic [7:0]            zpx_s;
  logic [ADDR_WIDTH-1:0] ptr_ext_s;

  // Zero-page indexing wraps inside page zero, so the add is only 8 bits wide.
  assign zpx_s     = op_i[7:0] + x_i[7:0];
  assign ptr_ext_s = {{(ADDR_WIDTH-16){1'b0}}, ptr_i};

  // Mode mux; all sums truncate to the address width.
  always_comb begin
    ea_o = '0;
    case (mode_i)
      MODE_ZP:         ea_o = {{(ADDR_WIDTH-8){1'b0}}, op_i[7:0]};
      MODE_INDEXED_X:  ea_o = {{(ADDR_WIDTH-8){1'b0}}, zpx_s};
      MODE_ABSOLUTE:   ea_o = op_i;
      MODE_ABSOLUTE_X: ea_o = op_i + x_i;
      MODE_ABSOLUTE_Y: ea_o = op_i + y_i;
      MODE_INDIRECT_X: ea_o = ptr_ext_s;
      MODE_INDIRECT_Y: ea_o = ptr_ext_s + y_i;
      MODE_IMMEDIATE:  ea_o = pc_i;
      default:         ea_o = '0;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch unit between decode and execute.
// Reads 0..3 operand bytes after the opcode, follows a zero-page pointer for
// the indirect modes, and presents operand, effective address and next PC.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle request, honoured only in IDLE
//   mode, extra_bytes   addressing mode and operand byte count (latched)
//   pc, reg_x, reg_y    first operand address and index registers (latched)
//   mem_address, mem_bus_enable, mem_read_data, mem_data_ready
//                       byte-wide read port, one read outstanding
//   operand, effective_address, next_pc
//                       results, valid from done and held afterwards
//   busy, done          activity flag and one-cycle completion pulse
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = OF_ADDR_WIDTH,
  parameter int REG_WIDTH  = OF_REG_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            mode,
  input  logic [2:0]            extra_bytes,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [REG_WIDTH-1:0]  reg_x,
  input  logic [REG_WIDTH-1:0]  reg_y,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_bus_enable,
  input  logic [7:0]            mem_read_data,
  input  logic                  mem_data_ready,
  output logic [ADDR_WIDTH-1:0] operand,
  output logic [ADDR_WIDTH-1:0] effective_address,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [1:0]            nbytes_q, nbytes_d;
  logic [1:0]            idx_q, idx_d;
  logic                  ptr_sel_q, ptr_sel_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] x_q, x_d;
  logic [ADDR_WIDTH-1:0] y_q, y_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] op_q, op_d;
  logic [7:0]            ptr_lo_q, ptr_lo_d;
  logic [7:0]            ptr_hi_q, ptr_hi_d;
  logic [ADDR_WIDTH-1:0] operand_q, operand_d;
  logic [ADDR_WIDTH-1:0] ea_q, ea_d;
  logic [ADDR_WIDTH-1:0] npc_q, npc_d;

  logic [ADDR_WIDTH-1:0] op_merged_s;
  logic [7:0]            ptr_base_s;
  logic [ADDR_WIDTH-1:0] ea_s;
  logic                  unused_s;

  // Only the low address-width bits of the index registers take part.
  assign unused_s = ^{reg_x[REG_WIDTH-1:ADDR_WIDTH], reg_y[REG_WIDTH-1:ADDR_WIDTH]};

  function automatic logic [ADDR_WIDTH-1:0] zp_addr(input logic [7:0] b);
    return {{(ADDR_WIDTH-8){1'b0}}, b};
  endfunction

  // Operand with the byte arriving this cycle inserted at its little-endian slot.
  always_comb begin
    op_merged_s = op_q;
    op_merged_s[{idx_q, 3'b000} +: 8] = mem_read_data;
  end

  // Pointer base uses the freshly merged byte so the pointer read follows the
  // last operand byte with no bubble.
  assign ptr_base_s = op_merged_s[7:0] + ((mode_q == MODE_INDIRECT_X) ? x_q[7:0] : 8'h00);

  operand_fetch_ea_calc #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ea_calc (
    .mode_i (mode_q),
    .op_i   (op_q),
    .pc_i   (pc_q),
    .x_i    (x_q),
    .y_i    (y_q),
    .ptr_i  ({ptr_hi_q, ptr_lo_q}),
    .ea_o   (ea_s)
  );

  // Next-state and datapath update for the fetch sequence.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    nbytes_d  = nbytes_q;
    idx_d     = idx_q;
    ptr_sel_d = ptr_sel_q;
    pc_d      = pc_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    op_d      = op_q;
    ptr_lo_d  = ptr_lo_q;
    ptr_hi_d  = ptr_hi_q;
    operand_d = operand_q;
    ea_d      = ea_q;
    npc_d     = npc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = mode_e'(mode);
          nbytes_d  = clip_bytes(extra_bytes);
          pc_d      = pc;
          x_d       = reg_x[ADDR_WIDTH-1:0];
          y_d       = reg_y[ADDR_WIDTH-1:0];
          addr_d    = pc;
          idx_d     = 2'd0;
          ptr_sel_d = 1'b0;
          op_d      = '0;
          ptr_lo_d  = 8'h00;
          ptr_hi_d  = 8'h00;
          state_d   = (clip_bytes(extra_bytes) != 2'd0) ? ST_FETCH_OP : ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH_OP: begin
        if (mem_data_ready) begin
          op_d = op_merged_s;
          if (idx_q == (nbytes_q - 2'd1)) begin
            if (is_indirect(mode_q)) begin
              addr_d  = zp_addr(ptr_base_s);
              state_d = ST_FETCH_PTR;
            end else begin
              state_d = ST_CALC;
            end
          end else begin
            idx_d  = idx_q + 2'd1;
            addr_d = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_FETCH_OP;
        end
      end
      ST_FETCH_PTR: begin
        if (mem_data_ready) begin
          if (!ptr_sel_q) begin
            ptr_lo_d  = mem_read_data;
            ptr_sel_d = 1'b1;
            // High pointer byte wraps within page zero.
            addr_d    = zp_addr(addr_q[7:0] + 8'h01);
          end else begin
            ptr_hi_d = mem_read_data;
            state_d  = ST_CALC;
          end
        end else begin
          state_d = ST_FETCH_PTR;
        end
      end
      ST_CALC: begin
        operand_d = op_q;
        ea_d      = ea_s;
        npc_d     = pc_q + {{(ADDR_WIDTH-2){1'b0}}, nbytes_q};
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any fetch in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_NONE;
      nbytes_q  <= 2'd0;
      idx_q     <= 2'd0;
      ptr_sel_q <= 1'b0;
      pc_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      op_q      <= '0;
      ptr_lo_q  <= 8'h00;
      ptr_hi_q  <= 8'h00;
      operand_q <= '0;
      ea_q      <= '0;
      npc_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      nbytes_q  <= nbytes_d;
      idx_q     <= idx_d;
      ptr_sel_q <= ptr_sel_d;
      pc_q      <= pc_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      ptr_lo_q  <= ptr_lo_d;
      ptr_hi_q  <= ptr_hi_d;
      operand_q <= operand_d;
      ea_q      <= ea_d;
      npc_q     <= npc_d;
    end
  end

  // Status and bus strobes decode directly from the state register.
  assign mem_bus_enable    = (state_q == ST_FETCH_OP) || (state_q == ST_FETCH_PTR);
  assign busy              = mem_bus_enable || (state_q == ST_CALC);
  assign done              = (state_q == ST_DONE);
  assign mem_address       = addr_q;
  assign operand           = operand_q;
  assign effective_address = ea_q;
  assign next_pc           = npc_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: a byte memory with configurable
// wait states, a behavioural model of each request, one per-cycle compare
// process, and literal expectations for the worked examples.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  mode;
  logic [2:0]  extra_bytes;
  logic [23:0] pc;
  logic [31:0] reg_x, reg_y;
  logic [23:0] mem_address;
  logic        mem_bus_enable;
  logic [7:0]  mem_read_data = 8'h00;
  logic        mem_data_ready = 1'b0;
  logic [23:0] operand, effective_address, next_pc;
  logic        busy, done;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .extra_bytes(extra_bytes),
    .pc(pc), .reg_x(reg_x), .reg_y(reg_y), .mem_address(mem_address),
    .mem_bus_enable(mem_bus_enable), .mem_read_data(mem_read_data),
    .mem_data_ready(mem_data_ready), .operand(operand),
    .effective_address(effective_address), .next_pc(next_pc), .busy(busy), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem [int unsigned];
  int          ws = 0;
  int          wcnt = 0;
  int unsigned rd_log[$];
  int unsigned exp_reads[$];
  logic [23:0] exp_op, exp_ea, exp_npc;
  int          exp_done_cyc = 0;
  int          cyc = 0;
  int          done_at = -1;
  bit          active = 1'b0;
  bit          done_seen = 1'b0;
  bit          prev_wait = 1'b0;
  logic [23:0] prev_addr = 24'h0;

  function automatic logic [7:0] rdm(input int unsigned a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Memory responder: ready after ws stall cycles, data looked up from mem.
  always @(negedge clk) begin
    mem_data_ready = mem_bus_enable && (wcnt >= ws);
    mem_read_data  = mem_bus_enable ? rdm(32'(mem_address)) : 8'h00;
  end

  // Log completed reads and advance the wait-state counter.
  always @(posedge clk) begin
    if (mem_bus_enable && mem_data_ready) begin
      rd_log.push_back(32'(mem_address));
      wcnt = 0;
    end else if (mem_bus_enable) begin
      wcnt++;
    end else begin
      wcnt = 0;
    end
  end

  // Per-cycle comparison of DUT outputs against the model while a request runs.
  always @(negedge clk) begin
    #1;
    if (active) begin
      chk("busy", 32'(busy), 32'(cyc < exp_done_cyc));
      chk("done", 32'(done), 32'(cyc == exp_done_cyc));
      if (prev_wait) chk("addr_hold", 32'({mem_bus_enable, mem_address}), 32'({1'b1, prev_addr}));
      if (done) begin
        done_at = cyc;
        chk("operand", 32'(operand), 32'(exp_op));
        chk("ea", 32'(effective_address), 32'(exp_ea));
        chk("next_pc", 32'(next_pc), 32'(exp_npc));
        chk("read_count", 32'(rd_log.size()), 32'(exp_reads.size()));
        foreach (exp_reads[i])
          chk("read_addr", (i < rd_log.size()) ? rd_log[i] : 32'hFFFF_FFFF, exp_reads[i]);
        done_seen = 1'b1;
      end
      prev_wait = mem_bus_enable && !mem_data_ready;
      prev_addr = mem_address;
    end else begin
      prev_wait = 1'b0;
    end
  end

  // Build the expectation from the addressing rules, then drive one request.
  task automatic run(input string name, input logic [3:0] m, input logic [2:0] eb,
                     input logic [23:0] p, input logic [31:0] x, input logic [31:0] y,
                     input int w, input bit poke);
    int          nb;
    int unsigned a, b1;
    logic [7:0]  base, lo, hi;
    logic [23:0] ptr;
    nb = (eb > 3'd3) ? 3 : int'(eb);
    exp_reads.delete();
    exp_op = 24'h0;
    for (int i = 0; i < nb; i++) begin
      a = (32'(p) + 32'(i)) & 32'h00FF_FFFF;
      exp_reads.push_back(a);
      exp_op = exp_op | (24'(rdm(a)) << (8 * i));
    end
    ptr = 24'h0;
    if ((m == MODE_INDIRECT_X || m == MODE_INDIRECT_Y) && nb > 0) begin
      base = exp_op[7:0] + ((m == MODE_INDIRECT_X) ? x[7:0] : 8'h00);
      b1   = (32'(base) + 32'd1) % 32'd256;
      lo   = rdm(32'(base));
      hi   = rdm(b1);
      exp_reads.push_back(32'(base));
      exp_reads.push_back(b1);
      ptr  = {8'h00, hi, lo};
    end
    case (m)
      MODE_ZP:         exp_ea = {16'h0, exp_op[7:0]};
      MODE_INDEXED_X:  exp_ea = 24'((32'(exp_op[7:0]) + 32'(x[7:0])) % 32'd256);
      MODE_ABSOLUTE:   exp_ea = exp_op;
      MODE_ABSOLUTE_X: exp_ea = 24'(32'(exp_op) + x);
      MODE_ABSOLUTE_Y: exp_ea = 24'(32'(exp_op) + y);
      MODE_INDIRECT_X: exp_ea = ptr;
      MODE_INDIRECT_Y: exp_ea = 24'(32'(ptr) + y);
      MODE_IMMEDIATE:  exp_ea = p;
      default:         exp_ea = 24'h0;
    endcase
    exp_npc      = 24'(32'(p) + 32'(nb));
    exp_done_cyc = exp_reads.size() * (w + 1) + 1;

    ws = w;
    rd_log.delete();
    done_seen = 1'b0;
    done_at = -1;
    @(negedge clk);
    mode = m; extra_bytes = eb; pc = p; reg_x = x; reg_y = y; start = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after acceptance: the DUT must use its latched copies.
    start = 1'b0; mode = ~m; extra_bytes = ~eb; pc = ~p; reg_x = ~x; reg_y = ~y;
    cyc = 0;
    active = 1'b1;
    @(negedge clk); #2;
    while (!done_seen && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start = poke && (cyc == 2);
      @(negedge clk); #2;
    end
    active = 1'b0;
    start = 1'b0;
    if (!done_seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: done not seen within 400 cycles", name);
    end
    if (poke) begin
      // start sampled while the DUT sits in DONE
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk); #2;
      chk({name, "_start_in_done_busy"}, 32'(busy), 32'd0);
      chk({name, "_start_in_done_enable"}, 32'(mem_bus_enable), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 4'd0; extra_bytes = 3'd0;
    pc = 24'h0; reg_x = 32'h0; reg_y = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_enable", 32'(mem_bus_enable), 32'd0);
    chk("rst_outputs", 32'(operand | effective_address | next_pc | mem_address), 32'd0);
    reset = 1'b0;

    // Two-byte absolute, zero-wait: done in the cycle after edge 3.
    mem[32'h1000] = 8'h34; mem[32'h1001] = 8'h12;
    run("t1_abs", MODE_ABSOLUTE, 3'd2, 24'h001000, 32'h0, 32'h0, 0, 1'b0);
    chk("t1_ea_lit", 32'(effective_address), 32'h001234);
    chk("t1_npc_lit", 32'(next_pc), 32'h001002);
    chk("t1_done_cycle", 32'(done_at), 32'd3);

    // Zero-page indexed wraps inside page zero.
    mem[32'h2000] = 8'hF0;
    run("t2_zpx", MODE_INDEXED_X, 3'd1, 24'h002000, 32'h20, 32'h0, 0, 1'b0);
    chk("t2_ea_lit", 32'(effective_address), 32'h000010);
    chk("t2_done_cycle", 32'(done_at), 32'd2);

    // Indirect-Y with pointer at $FF: high byte comes from $00.
    mem[32'h3000] = 8'hFF; mem[32'hFF] = 8'h00; mem[32'h0] = 8'h20;
    run("t3_indy", MODE_INDIRECT_Y, 3'd1, 24'h003000, 32'h0, 32'h5, 0, 1'b0);
    chk("t3_ea_lit", 32'(effective_address), 32'h002005);
    chk("t3_rd1_lit", (rd_log.size() > 1) ? rd_log[1] : 32'hFFFF_FFFF, 32'h0000FF);
    chk("t3_rd2_lit", (rd_log.size() > 2) ? rd_log[2] : 32'hFFFF_FFFF, 32'h000000);

    // Absolute-X: operand reads wrap past $FFFFFF, sum wraps at 2^24.
    mem[32'hFFFFFF] = 8'hFE; mem[32'h0] = 8'hFF; mem[32'h1] = 8'hFF;
    run("t4_absx", MODE_ABSOLUTE_X, 3'd3, 24'hFFFFFF, 32'h3, 32'h0, 0, 1'b0);
    chk("t4_ea_lit", 32'(effective_address), 32'h000001);
    chk("t4_npc_lit", 32'(next_pc), 32'h000002);
    chk("t4_op_lit", 32'(operand), 32'hFFFFFE);

    // Three wait states per read, start pulsed while busy and in DONE.
    // Two reads of four cycles each: 3 + 2*3 = 9.
    run("t5_wait", MODE_ABSOLUTE, 3'd2, 24'h001000, 32'h0, 32'h0, 3, 1'b1);
    chk("t5_ea_lit", 32'(effective_address), 32'h001234);
    chk("t5_done_cycle", 32'(done_at), 32'd9);

    // Indirect-X pointer at $FF wraps to $00 for the high byte.
    mem[32'h4000] = 8'hFE; mem[32'hFF] = 8'h78; mem[32'h0] = 8'h56;
    run("indx", MODE_INDIRECT_X, 3'd1, 24'h004000, 32'h1, 32'h0, 0, 1'b0);
    chk("indx_ea_lit", 32'(effective_address), 32'h005678);

    run("imm", MODE_IMMEDIATE, 3'd2, 24'h005000, 32'h0, 32'h0, 0, 1'b0);
    chk("imm_ea_lit", 32'(effective_address), 32'h005000);

    run("none0", MODE_NONE, 3'd0, 24'h006000, 32'h0, 32'h0, 0, 1'b0);
    chk("none0_done_cycle", 32'(done_at), 32'd1);

    // extra_bytes 7 clips to 3.
    mem[32'h7000] = 8'h11; mem[32'h7001] = 8'h22; mem[32'h7002] = 8'h33;
    run("clip", MODE_ABSOLUTE, 3'd7, 24'h007000, 32'h0, 32'h0, 0, 1'b0);
    chk("clip_npc_lit", 32'(next_pc), 32'h007003);
    chk("clip_ea_lit", 32'(effective_address), 32'h332211);

    mem[32'h8000] = 8'hF0; mem[32'h8001] = 8'hFF;
    run("absy", MODE_ABSOLUTE_Y, 3'd2, 24'h008000, 32'h0, 32'hFF00_1020, 0, 1'b0);
    chk("absy_ea_lit", 32'(effective_address), 32'h011010);

    run("stackrel", MODE_STACK_RELATIVE, 3'd1, 24'h00A000, 32'h0, 32'h0, 0, 1'b0);
    mem[32'h9000] = 8'h80;
    run("zp", MODE_ZP, 3'd1, 24'h009000, 32'h0, 32'h0, 2, 1'b0);
    chk("zp_ea_lit", 32'(effective_address), 32'h000080);

    // Reset during the second operand read aborts cleanly.
    ws = 0;
    @(negedge clk);
    mode = MODE_ABSOLUTE; extra_bytes = 3'd2; pc = 24'h001000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_enable", 32'(mem_bus_enable), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_outputs", 32'(operand | effective_address | next_pc), 32'd0);
    // start coincident with reset is ignored
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk); #2;
    chk("t6_start_in_reset", 32'(busy), 32'd0);
    run("t6_after", MODE_ABSOLUTE, 3'd2, 24'h001000, 32'h0, 32'h0, 0, 1'b0);
    chk("t6_after_ea_lit", 32'(effective_address), 32'h001234);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
